// File: rtl/lod_norm_pipe_if.sv
// Bundle of the input/output handshake and data signals of lod_norm_pipe.
// slave modport is the pipeline side, master modport is the producer/consumer side.
interface lod_norm_pipe_if #(
    parameter int X_LEN = 74,
    parameter int TAG_W = 4,
    parameter int CNT_W = $clog2(X_LEN + 1)
);
    logic             in_valid_i;
    logic             in_ready_o;
    logic [X_LEN-1:0] data_i;
    logic [TAG_W-1:0] tag_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [CNT_W-1:0] shift_num_o;
    logic             allzero_o;
    logic [TAG_W-1:0] tag_o;
    logic [X_LEN-1:0] data_o;

    modport slave (
        input  in_valid_i, data_i, tag_i, out_ready_i,
        output in_ready_o, out_valid_o, shift_num_o, allzero_o, tag_o, data_o
    );

    modport master (
        output in_valid_i, data_i, tag_i, out_ready_i,
        input  in_ready_o, out_valid_o, shift_num_o, allzero_o, tag_o, data_o
    );
endinterface

// File: rtl/lod_norm_pipe.sv
// Two-stage leading-one detector / normaliser with valid/ready flow control.
// Stage 1 registers the beat plus one zero flag per SEG_W segment; stage 2 picks the
// first non-zero segment from the MSB end and priority-encodes inside it.
// Optional feature macro: LOD_NORM_SHIFT_EN (adds the left-normalising barrel shift).
module lod_norm_pipe #(
    parameter int X_LEN = 74,
    parameter int SEG_W = 8,
    parameter int TAG_W = 4,
    parameter int CNT_W = $clog2(X_LEN + 1)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          flush_i,
    lod_norm_pipe_if.slave bus
);
    localparam int NSEG  = (X_LEN + SEG_W - 1) / SEG_W;
    localparam int SEL_W = (NSEG > 1) ? $clog2(NSEG) : 1;
    localparam int POS_W = (SEG_W > 1) ? $clog2(SEG_W) : 1;

    // stage registers
    logic             r_s1_valid;
    logic [X_LEN-1:0] r_s1_data;
    logic [TAG_W-1:0] r_s1_tag;
    logic [NSEG-1:0]  r_s1_segz;
    logic             r_s2_valid;
    logic [CNT_W-1:0] r_s2_cnt;
    logic             r_s2_allzero;
    logic [TAG_W-1:0] r_s2_tag;
    logic [X_LEN-1:0] r_s2_data;

    // handshake and datapath wires
    logic             w_s2_adv;
    logic             w_s1_adv;
    logic             w_accept;
    logic [NSEG-1:0]  w_in_segz;
    logic [SEG_W-1:0] w_in_seg [NSEG];
    logic [SEG_W-1:0] w_s1_seg [NSEG];
    logic             w_seg_found;
    logic [SEL_W-1:0] w_sel;
    logic [SEG_W-1:0] w_sel_seg;
    logic             w_bit_found;
    logic [POS_W-1:0] w_pos_in;
    logic [CNT_W-1:0] w_cnt;
    logic             w_allzero;
    logic [X_LEN-1:0] w_norm;

    // A stage may take new data when it is empty or its content leaves this cycle.
    assign w_s2_adv = !r_s2_valid || bus.out_ready_i;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;
    assign w_accept = bus.in_valid_i && w_s1_adv;

    assign bus.in_ready_o  = w_s1_adv;
    assign bus.out_valid_o = r_s2_valid;
    assign bus.shift_num_o = r_s2_cnt;
    assign bus.allzero_o   = r_s2_allzero;
    assign bus.tag_o       = r_s2_tag;
    assign bus.data_o      = r_s2_data;

    // Slice input and stage-1 data into segments; the top segment may be short and is
    // zero-extended at its upper end so its bit positions keep their absolute meaning.
    generate
        for (genvar gi = 0; gi < NSEG; gi++) begin : g_seg
            localparam int LO  = gi * SEG_W;
            localparam int HI  = (LO + SEG_W > X_LEN) ? X_LEN - 1 : LO + SEG_W - 1;
            localparam int LEN = HI - LO + 1;
            if (LEN == SEG_W) begin : g_full
                assign w_in_seg[gi] = bus.data_i[HI:LO];
                assign w_s1_seg[gi] = r_s1_data[HI:LO];
            end else begin : g_short
                assign w_in_seg[gi] = {{(SEG_W - LEN){1'b0}}, bus.data_i[HI:LO]};
                assign w_s1_seg[gi] = {{(SEG_W - LEN){1'b0}}, r_s1_data[HI:LO]};
            end
            assign w_in_segz[gi] = ~|w_in_seg[gi];
        end
    endgenerate

    // Stage-2 count: first non-zero segment from the top, then first set bit inside it.
    always_comb begin
        w_seg_found = 1'b0;
        w_sel       = '0;
        w_bit_found = 1'b0;
        w_pos_in    = '0;
        for (int s = NSEG - 1; s >= 0; s--) begin
            if (!w_seg_found && !r_s1_segz[s]) begin
                w_seg_found = 1'b1;
                w_sel       = SEL_W'(s);
            end
        end
        w_sel_seg = w_s1_seg[w_sel];
        for (int b = SEG_W - 1; b >= 0; b--) begin
            if (!w_bit_found && w_sel_seg[b]) begin
                w_bit_found = 1'b1;
                w_pos_in    = POS_W'(b);
            end
        end
        w_allzero = !w_seg_found;
        if (w_seg_found) begin
            w_cnt = CNT_W'(X_LEN - 1 - (int'(w_sel) * SEG_W + int'(w_pos_in)));
        end else begin
            w_cnt = CNT_W'(X_LEN);
        end
    end

    // Normalised data: a shift by X_LEN (all-zero case) yields zero naturally.
`ifdef LOD_NORM_SHIFT_EN
    assign w_norm = r_s1_data << w_cnt;
`else
    assign w_norm = r_s1_data;
`endif

    // Stage 1: capture accepted beat and its segment zero flags.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_s1_tag   <= '0;
            r_s1_segz  <= '0;
        end else if (flush_i) begin
            r_s1_valid <= 1'b0;
        end else if (w_s1_adv) begin
            r_s1_valid <= bus.in_valid_i;
            if (bus.in_valid_i) begin
                r_s1_data <= bus.data_i;
                r_s1_tag  <= bus.tag_i;
                r_s1_segz <= w_in_segz;
            end
        end
    end

    // Stage 2: register count, flag, tag and data; held while the output is stalled.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_s2_valid   <= 1'b0;
            r_s2_cnt     <= '0;
            r_s2_allzero <= 1'b0;
            r_s2_tag     <= '0;
            r_s2_data    <= '0;
        end else if (flush_i) begin
            r_s2_valid <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_cnt     <= w_cnt;
                r_s2_allzero <= w_allzero;
                r_s2_tag     <= r_s1_tag;
                r_s2_data    <= w_norm;
            end
        end
    end
endmodule

// File: tb/tb_lod_norm_pipe.sv
// Directed bench for lod_norm_pipe: vector table with latency checks, plus streaming,
// stall, flush and mid-stall reset sequences checked by an in-order scoreboard.
module tb_lod_norm_pipe;
    localparam int X = 74;
    localparam int T = 4;
    localparam int C = 7;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    lod_norm_pipe_if #(.X_LEN(X), .TAG_W(T), .CNT_W(C)) bus ();

    lod_norm_pipe #(.X_LEN(X), .SEG_W(8), .TAG_W(T), .CNT_W(C)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .flush_i (flush),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [X-1:0] data;
        logic [T-1:0] tag;
        logic [C-1:0] cnt;
        logic         az;
    } vec_t;

    typedef struct {
        logic [C-1:0] cnt;
        logic         az;
        logic [T-1:0] tag;
        logic [X-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   acc_cyc[$];
    int   pop_cyc[$];
    bit   rec_en = 1'b0;

    task automatic chk(input string nm, input logic [X-1:0] act, input logic [X-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    function automatic logic [C-1:0] ref_cnt(input logic [X-1:0] d);
        for (int i = X - 1; i >= 0; i--) begin
            if (d[i]) return C'(X - 1 - i);
        end
        return C'(X);
    endfunction

    function automatic logic [X-1:0] ref_data(input logic [X-1:0] d, input logic [C-1:0] c);
`ifdef LOD_NORM_SHIFT_EN
        return d << c;
`else
        return (c == C'(X)) ? d : d;
`endif
    endfunction

    // Scoreboard: push accepted beats, pop and compare delivered results, in order.
    always @(negedge clk) begin
        if (!rst_n || flush) begin
            exp_q.delete();
        end else begin
            if (bus.out_valid_o && bus.out_ready_i) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_out", 74'(1), 74'(0));
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("sb_cnt", 74'(bus.shift_num_o), 74'(e.cnt));
                    chk("sb_az", 74'(bus.allzero_o), 74'(e.az));
                    chk("sb_tag", 74'(bus.tag_o), 74'(e.tag));
                    chk("sb_data", bus.data_o, e.data);
                end
                if (rec_en) pop_cyc.push_back(cyc);
            end
            if (bus.in_valid_i && bus.in_ready_o) begin
                exp_t n;
                n.cnt  = ref_cnt(bus.data_i);
                n.az   = (bus.data_i == '0);
                n.tag  = bus.tag_i;
                n.data = ref_data(bus.data_i, n.cnt);
                exp_q.push_back(n);
                if (rec_en) acc_cyc.push_back(cyc);
            end
        end
    end

    // Offer one beat (called at posedge+1) and hold it until accepted.
    task automatic drive(input logic [X-1:0] d, input logic [T-1:0] t);
        int n;
        bus.in_valid_i = 1'b1;
        bus.data_i     = d;
        bus.tag_i      = t;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready_o && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!bus.in_ready_o) chk("drive_timeout", 74'(0), 74'(1));
        @(posedge clk);
        #1;
        bus.in_valid_i = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || bus.out_valid_o) && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("drain_empty", 74'(exp_q.size()), 74'(0));
    endtask

    vec_t vt[13];
    int   acc;
    logic [X-1:0] sb[8];

    initial begin
        bus.in_valid_i  = 1'b0;
        bus.data_i      = '0;
        bus.tag_i       = '0;
        bus.out_ready_i = 1'b1;

        vt[0]  = '{74'(1) << 73, 4'd3, 7'd0, 1'b0};
        vt[1]  = '{74'(1), 4'd1, 7'd73, 1'b0};
        vt[2]  = '{74'(0), 4'd2, 7'd74, 1'b1};
        vt[3]  = '{74'(1) << 72, 4'd4, 7'd1, 1'b0};
        vt[4]  = '{74'(1) << 71, 4'd5, 7'd2, 1'b0};
        vt[5]  = '{74'(1) << 64, 4'd6, 7'd9, 1'b0};
        vt[6]  = '{74'(1) << 63, 4'd7, 7'd10, 1'b0};
        vt[7]  = '{74'(1) << 8, 4'd8, 7'd65, 1'b0};
        vt[8]  = '{74'(1) << 7, 4'd9, 7'd66, 1'b0};
        vt[9]  = '{74'h3F, 4'd10, 7'd68, 1'b0};
        vt[10] = '{(74'(1) << 40) | 74'(1), 4'd11, 7'd33, 1'b0};
        vt[11] = '{~74'(0), 4'd12, 7'd0, 1'b0};
        vt[12] = '{(74'(1) << 16) | (74'(1) << 15), 4'd15, 7'd57, 1'b0};

        // reset state
        #2;
        chk("rst_out_valid", 74'(bus.out_valid_o), 74'(0));
        chk("rst_in_ready", 74'(bus.in_ready_o), 74'(1));
        chk("rst_shift_num", 74'(bus.shift_num_o), 74'(0));
        chk("rst_allzero", 74'(bus.allzero_o), 74'(0));
        chk("rst_tag", 74'(bus.tag_o), 74'(0));
        chk("rst_data", bus.data_o, 74'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // vector table: one beat each, latency and result fields
        for (int i = 0; i < 13; i++) begin
            @(posedge clk);
            #1;
            bus.in_valid_i = 1'b1;
            bus.data_i     = vt[i].data;
            bus.tag_i      = vt[i].tag;
            @(posedge clk);
            #1;
            bus.in_valid_i = 1'b0;
            chk($sformatf("v%0d_lat1_valid", i), 74'(bus.out_valid_o), 74'(0));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_lat2_valid", i), 74'(bus.out_valid_o), 74'(1));
            chk($sformatf("v%0d_cnt", i), 74'(bus.shift_num_o), 74'(vt[i].cnt));
            chk($sformatf("v%0d_az", i), 74'(bus.allzero_o), 74'(vt[i].az));
            chk($sformatf("v%0d_tag", i), 74'(bus.tag_o), 74'(vt[i].tag));
`ifdef LOD_NORM_SHIFT_EN
            chk($sformatf("v%0d_data", i), bus.data_o, vt[i].data << vt[i].cnt);
`else
            chk($sformatf("v%0d_data", i), bus.data_o, vt[i].data);
`endif
        end
        wait_drain();

        // streaming: one beat per segment boundary, back to back
        acc_cyc.delete();
        pop_cyc.delete();
        rec_en = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) drive(74'(1) << (8 * i), T'(i));
        wait_drain();
        rec_en = 1'b0;
        chk("stream_acc_n", 74'(acc_cyc.size()), 74'(10));
        chk("stream_pop_n", 74'(pop_cyc.size()), 74'(10));
        if (acc_cyc.size() == 10) chk("stream_acc_span", 74'(acc_cyc[9] - acc_cyc[0]), 74'(9));
        if (pop_cyc.size() == 10) chk("stream_pop_span", 74'(pop_cyc[9] - pop_cyc[0]), 74'(9));

        // stall: two beats fill the pipe, outputs hold, then drain with push+pop
        for (int i = 0; i < 8; i++) sb[i] = 74'(5) << (9 * i);
        bus.out_ready_i = 1'b0;
        @(posedge clk);
        #1;
        acc = 0;
        bus.in_valid_i = 1'b1;
        bus.data_i     = sb[0];
        bus.tag_i      = 4'd0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (bus.in_ready_o) acc++;
            @(posedge clk);
            #1;
            bus.data_i = sb[acc];
            bus.tag_i  = T'(acc);
        end
        chk("stall_accepts", 74'(acc), 74'(2));
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("stall_in_ready", 74'(bus.in_ready_o), 74'(0));
            chk("stall_out_valid", 74'(bus.out_valid_o), 74'(1));
            chk("stall_hold_cnt", 74'(bus.shift_num_o), 74'(ref_cnt(sb[0])));
            chk("stall_hold_tag", 74'(bus.tag_o), 74'(0));
        end
        @(posedge clk);
        #1;
        bus.out_ready_i = 1'b1;
        while (acc < 8) begin
            @(negedge clk);
            if (bus.in_ready_o) acc++;
            @(posedge clk);
            #1;
            if (acc < 8) begin
                bus.data_i = sb[acc];
                bus.tag_i  = T'(acc);
            end
        end
        bus.in_valid_i = 1'b0;
        wait_drain();

        // flush with both stages full; offered beat in flush cycle is discarded
        bus.out_ready_i = 1'b0;
        @(posedge clk);
        #1;
        bus.in_valid_i = 1'b1;
        bus.data_i     = 74'(1) << 50;
        @(posedge clk);
        #1;
        bus.data_i = 74'(1) << 30;
        @(posedge clk);
        #1;
        chk("full_in_ready", 74'(bus.in_ready_o), 74'(0));
        flush = 1'b1;
        bus.data_i = 74'(1) << 20;
        @(posedge clk);
        #1;
        flush = 1'b0;
        bus.in_valid_i = 1'b0;
        chk("flush_out_valid", 74'(bus.out_valid_o), 74'(0));
        chk("flush_in_ready", 74'(bus.in_ready_o), 74'(1));
        bus.out_ready_i = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("flush_no_ghost", 74'(bus.out_valid_o), 74'(0));
        end
        bus.in_valid_i = 1'b1;
        bus.data_i     = 74'h3F;
        bus.tag_i      = 4'd6;
        @(posedge clk);
        #1;
        bus.in_valid_i = 1'b0;
        @(posedge clk);
        #1;
        chk("post_flush_valid", 74'(bus.out_valid_o), 74'(1));
        chk("post_flush_cnt", 74'(bus.shift_num_o), 74'(68));
        chk("post_flush_tag", 74'(bus.tag_o), 74'(6));
        wait_drain();

        // reset asserted while a result is held
        bus.out_ready_i = 1'b0;
        @(posedge clk);
        #1;
        bus.in_valid_i = 1'b1;
        bus.data_i     = 74'(1) << 10;
        @(posedge clk);
        #1;
        bus.in_valid_i = 1'b0;
        @(posedge clk);
        #1;
        chk("pre_rst_held", 74'(bus.out_valid_o), 74'(1));
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 74'(bus.out_valid_o), 74'(0));
        chk("async_rst_ready", 74'(bus.in_ready_o), 74'(1));
        @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        bus.out_ready_i = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("post_rst_no_out", 74'(bus.out_valid_o), 74'(0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
